// File: rtl/snoop_bus_arbiter.sv
// ---------------------------------------------------------------------------
// snoop_bus_arbiter
//
// Shared-bus coherence controller for the two-core SMP. It arbitrates read
// and write misses from both cores' Dcaches and snoops the non-requesting
// core. It also sequences writebacks, main-memory fills and cache-to-cache
// transfers under an MSI policy.
//
// Sequence: IDLE -> SNOOP -> [WB] -> [MEM_RD] -> DONE -> IDLE
//
// Optional feature macro: BUS_STATS_EN
//   When defined, this macro adds three 16-bit saturating counters. They
//   count grants completed per core and cache-to-cache fills.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_rd, req_wr      per-core level miss requests, held until done
//   req_addr0/1         per-core miss block address
//   snoop_state0/1      snooped block state per core (00=I, 01=S, 10=M)
//   snoop_found         per-core search hit
//   grant               one-hot bus owner (registered)
//   done                one-cycle completion pulse to the owner
//   snoop_search        search request to the non-owner
//   snoop_addr          address being searched, shared by both cores
//   snoop_flush         non-owner drives its modified block onto the bus
//   snoop_inval         one-cycle pulse that sets the non-owner's block to I
//   snoop_downgrade     one-cycle pulse that sets the non-owner's block M->S
//   mem_re, mem_we      memory read / write strobes
//   mem_addr            memory block address
//   fill_src            0 = fill from memory, 1 = fill from the bus
//   busy                high whenever not IDLE
//   stat_grants0/1,
//   stat_c2c            (BUS_STATS_EN only) saturating statistics counters
// ---------------------------------------------------------------------------
module snoop_bus_arbiter #(
    parameter int MEM_LAT = 4,
    parameter int ADDR_W  = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_rd,
    input  logic [1:0]        req_wr,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [1:0]        snoop_state0,
    input  logic [1:0]        snoop_state1,
    input  logic [1:0]        snoop_found,
    output logic [1:0]        grant,
    output logic [1:0]        done,
    output logic [1:0]        snoop_search,
    output logic [ADDR_W-1:0] snoop_addr,
    output logic [1:0]        snoop_flush,
    output logic [1:0]        snoop_inval,
    output logic [1:0]        snoop_downgrade,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              fill_src,
`ifdef BUS_STATS_EN
    output logic [15:0]       stat_grants0,
    output logic [15:0]       stat_grants1,
    output logic [15:0]       stat_c2c,
`endif
    output logic              busy
);

    localparam logic [3:0] LP_LAT_M1 = 4'(MEM_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SNOOP,
        S_WB,
        S_MEM_RD,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [1:0]        r_grant;
    logic              r_owner;       // 0 = core0, 1 = core1
    logic              r_is_wr;
    logic              r_last_grant;
    logic [3:0]        r_cnt;
    logic              r_oth_m;
    logic              r_oth_s;
    logic              r_c2c;
    logic [ADDR_W-1:0] r_addr;

    logic [1:0]        w_eff;
    logic              w_sel;
    logic              w_sel_wr;
    logic [1:0]        w_owner_oh;
    logic [1:0]        w_other_oh;
    logic              w_oth_found;
    logic [1:0]        w_oth_state;
    logic              w_oth_m;
    logic              w_oth_s;

    // Arbitration: a lone requester wins. On a tie, the core that did not
    // win last time wins. Holding rd and wr together counts as a write.
    assign w_eff    = req_rd | req_wr;
    assign w_sel    = (w_eff == 2'b11) ? ~r_last_grant : w_eff[1];
    assign w_sel_wr = w_sel ? req_wr[1] : req_wr[0];

    assign w_owner_oh  = r_owner ? 2'b10 : 2'b01;
    assign w_other_oh  = r_owner ? 2'b01 : 2'b10;
    assign w_oth_found = r_owner ? snoop_found[0] : snoop_found[1];
    assign w_oth_state = r_owner ? snoop_state0 : snoop_state1;
    assign w_oth_m     = w_oth_found && (w_oth_state == 2'b10);
    assign w_oth_s     = w_oth_found && (w_oth_state == 2'b01);

    assign grant = r_grant;
    assign busy  = (r_state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        done            = 2'b00;
        snoop_search    = 2'b00;
        snoop_addr      = '0;
        snoop_flush     = 2'b00;
        snoop_inval     = 2'b00;
        snoop_downgrade = 2'b00;
        mem_re          = 1'b0;
        mem_we          = 1'b0;
        mem_addr        = '0;
        fill_src        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|w_eff) w_state_nxt = S_SNOOP;
            end
            S_SNOOP: begin
                snoop_search = w_other_oh;
                snoop_addr   = r_addr;
                w_state_nxt  = w_oth_m ? S_WB : S_MEM_RD;
            end
            S_WB: begin
                mem_we      = 1'b1;
                mem_addr    = r_addr;
                snoop_flush = w_other_oh;
                // A read takes the flushed block straight off the bus. A
                // write still needs the freshly written-back copy from memory.
                if (r_cnt == 4'd0) w_state_nxt = r_is_wr ? S_MEM_RD : S_DONE;
            end
            S_MEM_RD: begin
                mem_re   = 1'b1;
                mem_addr = r_addr;
                if (r_cnt == 4'd0) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                done     = w_owner_oh;
                fill_src = r_c2c;
                if (r_is_wr && (r_oth_m || r_oth_s)) snoop_inval = w_other_oh;
                if (!r_is_wr && r_oth_m) snoop_downgrade = w_other_oh;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant      <= 2'b00;
            r_owner      <= 1'b0;
            r_is_wr      <= 1'b0;
            r_last_grant <= 1'b1;
            r_cnt        <= 4'd0;
            r_oth_m      <= 1'b0;
            r_oth_s      <= 1'b0;
            r_c2c        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|w_eff) begin
                        r_owner <= w_sel;
                        r_is_wr <= w_sel_wr;
                        r_grant <= w_sel ? 2'b10 : 2'b01;
                    end
                end
                S_SNOOP: begin
                    r_oth_m <= w_oth_m;
                    r_oth_s <= w_oth_s;
                    r_c2c   <= w_oth_m && !r_is_wr;
                    r_cnt   <= LP_LAT_M1;
                end
                S_WB: begin
                    // Reload on the way into MEM_RD for the write path.
                    r_cnt <= (r_cnt == 4'd0) ? LP_LAT_M1 : r_cnt - 4'd1;
                end
                S_MEM_RD: begin
                    if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
                end
                S_DONE: begin
                    r_last_grant <= r_owner;
                    r_grant      <= 2'b00;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && |w_eff) r_addr <= w_sel ? req_addr1 : req_addr0;
    end

`ifdef BUS_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_grants0 <= 16'h0000;
            stat_grants1 <= 16'h0000;
            stat_c2c     <= 16'h0000;
        end else if (r_state == S_DONE) begin
            if (!r_owner && stat_grants0 != 16'hFFFF) stat_grants0 <= stat_grants0 + 16'd1;
            if (r_owner && stat_grants1 != 16'hFFFF) stat_grants1 <= stat_grants1 + 16'd1;
            if (r_c2c && stat_c2c != 16'hFFFF) stat_c2c <= stat_c2c + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_snoop_bus_arbiter
//
// Directed testbench for snoop_bus_arbiter with MEM_LAT = 4. Inputs change
// on the falling edge, and outputs are sampled on the falling edge. The
// expected cycle counts are written out by hand for each transaction.
// ---------------------------------------------------------------------------
module tb_snoop_bus_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_rd;
    logic [1:0]  req_wr;
    logic [10:0] req_addr0;
    logic [10:0] req_addr1;
    logic [1:0]  snoop_state0;
    logic [1:0]  snoop_state1;
    logic [1:0]  snoop_found;
    logic [1:0]  grant;
    logic [1:0]  done;
    logic [1:0]  snoop_search;
    logic [10:0] snoop_addr;
    logic [1:0]  snoop_flush;
    logic [1:0]  snoop_inval;
    logic [1:0]  snoop_downgrade;
    logic        mem_re;
    logic        mem_we;
    logic [10:0] mem_addr;
    logic        fill_src;
    logic        busy;
`ifdef BUS_STATS_EN
    logic [15:0] stat_grants0;
    logic [15:0] stat_grants1;
    logic [15:0] stat_c2c;
`endif

    int n_chk;
    int n_bad;

    snoop_bus_arbiter #(.MEM_LAT(4), .ADDR_W(11)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_rd          (req_rd),
        .req_wr          (req_wr),
        .req_addr0       (req_addr0),
        .req_addr1       (req_addr1),
        .snoop_state0    (snoop_state0),
        .snoop_state1    (snoop_state1),
        .snoop_found     (snoop_found),
        .grant           (grant),
        .done            (done),
        .snoop_search    (snoop_search),
        .snoop_addr      (snoop_addr),
        .snoop_flush     (snoop_flush),
        .snoop_inval     (snoop_inval),
        .snoop_downgrade (snoop_downgrade),
        .mem_re          (mem_re),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .fill_src        (fill_src),
`ifdef BUS_STATS_EN
        .stat_grants0    (stat_grants0),
        .stat_grants1    (stat_grants1),
        .stat_c2c        (stat_c2c),
`endif
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, ".grant"}, {30'd0, grant}, 32'd0);
        check({tag, ".busy"}, {31'd0, busy}, 32'd0);
        check({tag, ".done"}, {30'd0, done}, 32'd0);
        check({tag, ".mem"}, {30'd0, mem_re, mem_we}, 32'd0);
        check({tag, ".maddr"}, {21'd0, mem_addr}, 32'd0);
        check({tag, ".snoop"}, {24'd0, snoop_search, snoop_flush, snoop_inval, snoop_downgrade}, 32'd0);
        check({tag, ".fill"}, {31'd0, fill_src}, 32'd0);
    endtask

    // The request is driven on a falling edge. nwb and nrd are the expected
    // WB and MEM_RD cycle counts, each worked out by hand. On the falling
    // edge where done is seen, the owner drops its request.
    task automatic txn(input string tag, input int c, input logic rd, input logic wr,
                       input logic [10:0] a, input int nwb, input int nrd,
                       input logic xfill, input logic xinv, input logic xdg);
        logic [1:0] own;
        logic [1:0] oth;
        own = (c == 1) ? 2'b10 : 2'b01;
        oth = (c == 1) ? 2'b01 : 2'b10;
        if (c == 1) begin
            req_addr1 = a; req_rd[1] = rd; req_wr[1] = wr;
        end else begin
            req_addr0 = a; req_rd[0] = rd; req_wr[0] = wr;
        end
        @(negedge clk);
        check({tag, ".grant"}, {30'd0, grant}, {30'd0, own});
        check({tag, ".search"}, {30'd0, snoop_search}, {30'd0, oth});
        check({tag, ".saddr"}, {21'd0, snoop_addr}, {21'd0, a});
        check({tag, ".busy"}, {31'd0, busy}, 32'd1);
        for (int i = 0; i < nwb; i++) begin
            @(negedge clk);
            check({tag, ".wb_strb"}, {30'd0, mem_re, mem_we}, 32'd1);
            check({tag, ".wb_flush"}, {30'd0, snoop_flush}, {30'd0, oth});
            check({tag, ".wb_addr"}, {21'd0, mem_addr}, {21'd0, a});
            check({tag, ".wb_done"}, {30'd0, done}, 32'd0);
        end
        for (int i = 0; i < nrd; i++) begin
            @(negedge clk);
            check({tag, ".rd_strb"}, {30'd0, mem_re, mem_we}, 32'd2);
            check({tag, ".rd_addr"}, {21'd0, mem_addr}, {21'd0, a});
            check({tag, ".rd_flush"}, {30'd0, snoop_flush}, 32'd0);
            check({tag, ".rd_done"}, {30'd0, done}, 32'd0);
        end
        @(negedge clk);
        check({tag, ".done"}, {30'd0, done}, {30'd0, own});
        check({tag, ".fill"}, {31'd0, fill_src}, {31'd0, xfill});
        check({tag, ".inval"}, {30'd0, snoop_inval}, xinv ? {30'd0, oth} : 32'd0);
        check({tag, ".dgrade"}, {30'd0, snoop_downgrade}, xdg ? {30'd0, oth} : 32'd0);
        check({tag, ".dn_strb"}, {30'd0, mem_re, mem_we}, 32'd0);
        req_rd[c] = 1'b0;
        req_wr[c] = 1'b0;
        @(negedge clk);
        check({tag, ".idle_busy"}, {31'd0, busy}, 32'd0);
        check({tag, ".idle_grant"}, {30'd0, grant}, 32'd0);
        check({tag, ".idle_done"}, {30'd0, done}, 32'd0);
    endtask

    task automatic snoop_set(input logic [1:0] f, input logic [1:0] s0, input logic [1:0] s1);
        snoop_found = f; snoop_state0 = s0; snoop_state1 = s1;
    endtask

    initial begin
        n_chk = 0;
        n_bad = 0;
        rst_n = 1'b0;
        req_rd = 2'b00;
        req_wr = 2'b00;
        req_addr0 = 11'h000;
        req_addr1 = 11'h000;
        snoop_set(2'b00, 2'b00, 2'b00);
        repeat (3) @(negedge clk);
        check_quiet("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_quiet("post_reset");

        // Both cores read out of reset: core0 wins first, then core1.
        req_rd[1] = 1'b1; req_addr1 = 11'h2AA;
        txn("arb0_c0", 0, 1'b1, 1'b0, 11'h155, 0, 4, 1'b0, 1'b0, 1'b0);
        txn("arb0_c1", 1, 1'b1, 1'b0, 11'h2AA, 0, 4, 1'b0, 1'b0, 1'b0);

        // Core0 read, core1 holds the block in I.
        txn("rd_i", 0, 1'b1, 1'b0, 11'h123, 0, 4, 1'b0, 1'b0, 1'b0);

        // Core1 write, core0 holds the block in M: writeback, then refill, then invalidate.
        snoop_set(2'b01, 2'b10, 2'b00);
        txn("wr_m", 1, 1'b0, 1'b1, 11'h040, 4, 4, 1'b0, 1'b1, 1'b0);

        // Core0 read, core1 holds the block in M: cache-to-cache transfer and downgrade.
        snoop_set(2'b10, 2'b00, 2'b10);
        txn("rd_m", 0, 1'b1, 1'b0, 11'h3C1, 4, 0, 1'b1, 1'b0, 1'b1);

        // Simultaneous reads after core0 last won: core1 goes first.
        snoop_set(2'b00, 2'b00, 2'b00);
        req_rd[0] = 1'b1; req_addr0 = 11'h011;
        txn("arb1_c1", 1, 1'b1, 1'b0, 11'h022, 0, 4, 1'b0, 1'b0, 1'b0);
        txn("arb1_c0", 0, 1'b1, 1'b0, 11'h011, 0, 4, 1'b0, 1'b0, 1'b0);

        // Core0 write, core1 holds the block in S: refill only, then invalidate.
        snoop_set(2'b10, 2'b00, 2'b01);
        txn("wr_s", 0, 1'b0, 1'b1, 11'h7FF, 0, 4, 1'b0, 1'b1, 1'b0);

        // Core1 holds rd and wr together, so the access counts as a write. Core0 holds the block in S.
        snoop_set(2'b01, 2'b01, 2'b00);
        txn("rdwr_s", 1, 1'b1, 1'b1, 11'h0F0, 0, 4, 1'b0, 1'b1, 1'b0);

        // Core0 read where core1 reports M but not found: this counts as a miss, so no WB.
        snoop_set(2'b00, 2'b00, 2'b10);
        txn("nofound", 0, 1'b1, 1'b0, 11'h555, 0, 4, 1'b0, 1'b0, 1'b0);

        // Reset during MEM_RD cycle 2.
        snoop_set(2'b00, 2'b00, 2'b00);
        req_rd[1] = 1'b1; req_addr1 = 11'h321;
        @(negedge clk);
        check("rst_mid.grant", {30'd0, grant}, 32'd2);
        @(negedge clk);
        @(negedge clk);
        check("rst_mid.rd2", {30'd0, mem_re, mem_we}, 32'd2);
        #1 rst_n = 1'b0;
        #1 check_quiet("rst_mid");
        req_rd = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("rst_mid.no_done", {30'd0, done}, 32'd0);
        end

        // After reset, last_grant is reloaded, so core0 wins the next tie.
        req_rd[1] = 1'b1; req_addr1 = 11'h077;
        txn("arb2_c0", 0, 1'b1, 1'b0, 11'h066, 0, 4, 1'b0, 1'b0, 1'b0);
        txn("arb2_c1", 1, 1'b1, 1'b0, 11'h077, 0, 4, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/snoop_bus_arbiter.md
Name: snoop_bus_arbiter

Overview:
Shared-bus coherence controller for the two-core SMP. It arbitrates read/write misses from both cores' Dcaches and snoops the non-requesting core through its cpu_search/bus_addr_in/cpu_datasel inputs. It sequences writebacks, main-memory fills and cache-to-cache transfers under an MSI policy. It sits between the per-core cpu instances and the shared memory.

Parameters:
MEM_LAT, 4, main-memory read or write duration in cycles (legal range 1..15)
ADDR_W, 11, block address width; matches the Dcache addr[12:2] index/tag field

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
req_rd  in  2  per-core read miss, level; held until done
req_wr  in  2  per-core write miss, level; held until done
req_addr0  in  ADDR_W  core0 miss block address
req_addr1  in  ADDR_W  core1 miss block address
snoop_state0  in  2  core0 block_state for the snooped address (00=I, 01=S, 10=M)
snoop_state1  in  2  core1 block_state for the snooped address
snoop_found  in  2  per-core cpu_search_found
grant  out  2  one-hot bus owner
done  out  2  one-cycle completion pulse to the owner
snoop_search  out  2  cpu_search to the non-owner
snoop_addr  out  ADDR_W  bus_addr_in, shared by both cores
snoop_flush  out  2  cpu_datasel; the non-owner drives its block onto the bus
snoop_inval  out  2  one-cycle pulse; the non-owner sets the block to I
snoop_downgrade  out  2  one-cycle pulse; the non-owner sets M to S
mem_re  out  1  memory read strobe
mem_we  out  1  memory write strobe
mem_addr  out  ADDR_W  memory block address
fill_src  out  1  0 = fill from memory, 1 = fill from the bus (cache-to-cache)
busy  out  1  high whenever the state is not IDLE

Behaviour:
- Reset: all outputs 0; state IDLE; last_grant = 1, so core0 wins the first conflict.
- A core's effective request is req_rd|req_wr. If both are high for one core, the access is treated as a write.
- States: IDLE, SNOOP, WB, MEM_RD, DONE.
- IDLE:
  - If any effective request is present: grant the single requester. If both request, grant the core != last_grant.
  - Latch the address and the op (rd/wr).
  - grant is registered and visible the cycle after the request is sampled. Go to SNOOP.
- SNOOP (1 cycle):
  - snoop_search[other]=1 and snoop_addr=latched address.
  - The other core's found/state respond combinationally and are sampled at the end of this cycle.
  - other_M = found & state==10; other_S = found & state==01.
  - If other_M: go to WB. Otherwise go to MEM_RD.
- WB (MEM_LAT cycles):
  - mem_we=1, mem_addr=latched address, snoop_flush[other]=1; a down-counter is loaded with MEM_LAT-1.
  - At count 0: for a read, go to DONE with fill_src=1. For a write, go to MEM_RD.
- MEM_RD (MEM_LAT cycles): mem_re=1, mem_addr=latched address, fill_src=0. At count 0, go to DONE.
- DONE (1 cycle):
  - done[owner]=1.
  - Write with other_M or other_S: snoop_inval[other]=1.
  - Read with other_M: snoop_downgrade[other]=1.
  - last_grant<=owner; grant clears on exit. Go to IDLE.
- Latency from the request sample edge to done high:
  - Read, other not M: MEM_LAT+1 edges (5).
  - Read, other M: MEM_LAT+1 edges, with fill_src=1.
  - Write, other M: 2*MEM_LAT+1 edges (9).
- Requesters drop their request on the edge where done is seen. IDLE follows DONE, so a stale request is never re-granted.
- A request deasserting mid-transaction does not abort it; the sequence completes.
- Requests arriving while busy wait; no queue is needed since requests are levels.
- Strobes are mutually exclusive: mem_re and mem_we are never high together.
- snoop_search, snoop_flush, snoop_inval and snoop_downgrade only ever target the non-owner.
- Reset mid-transaction returns to IDLE immediately with all outputs 0 and no done pulse.

Optional Feature:
BUS_STATS_EN: when defined, adds outputs stat_grants0, stat_grants1 and stat_c2c, each 16 bits. They are saturating counters incremented in DONE per owner, and for each fill_src=1 completion; all reset to 0 and hold at 16'hFFFF. When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Core0 req_rd, addr 0x123, core1 state I -> grant=01 after edge0, snoop_search=10 for one cycle, mem_re for 4 cycles, done[0] after edge5, fill_src=0, no inval.
- Core1 req_wr, addr 0x040, core0 found with state M -> WB 4 cycles (mem_we, snoop_flush[0]), then MEM_RD 4 cycles, done[1] with snoop_inval[0] after edge9.
- Core0 req_rd, core1 state M -> WB 4 cycles, done[0] with fill_src=1 and snoop_downgrade[1]; mem_re never asserts.
- Both cores request reads out of reset, held -> core0 granted first, then core1; repeat the simultaneous request -> core0 after core1 (alternation).
- Core0 write while core1 state S -> no WB, MEM_RD 4 cycles, snoop_inval[1] in DONE.
- rst_n low during MEM_RD cycle 2 -> all outputs 0 at once, busy=0, no done; the next request after reset is granted normally.
